lin_interp_48k: RTL and testbench
=================================

// Module: lin_interp_48k
// PURPOSE
//  Linear-interpolation upsampler placed directly downstream of the 48 kHz mix/scale stage.
//  - Input: one scaled sample per 48 kHz period (L+R or L-R path; one instance per channel).
//  - Output: R = 2**LOG2R straight-line points per input period, paced by the output-rate
//    clock enable, for the higher-rate modulator datapath.
// PARAMETERS
//  W      18  sample width, signed two's complement, input and output
//  LOG2R  2   log2 of the upsampling ratio (R=4 -> 192 kHz output rate)
// PORTS
//  clock      in   1  system clock; the only clock
//  reset      in   1  asynchronous, active-high reset
//  clken_48   in   1  one-cycle strobe: din holds a valid new sample this cycle
//  clken_out  in   1  one-cycle strobe at output rate; requests the next interpolated point
//  din        in   W  signed input sample (driven by the upstream multiplier result)
//  dout       out  W  signed interpolated sample, registered
//  dout_stb   out  1  one-cycle pulse: dout updated this cycle
//  slip       out  1  one-cycle pulse: rate mismatch between clken_48 and clken_out
// BEHAVIOUR
//  Reset (async, immediate): dout=0, dout_stb=0, slip=0, x0=x1=0, acc=0, phase=0, state=IDLE.
//  Registers
//  - x0, x1 (W bits): segment endpoints.
//  - diff = x1-x0 (W+1 bits).
//  - acc (W+LOG2R+1 bits): holds x0*R + k*diff.
//  - phase: 0..R.
//  Load (clken_48)
//  - x0<=x1, x1<=din, acc<=x1_old*R, phase<=0, state<=RUN.
//  - diff is recomputed from the new endpoints.
//  Tick (clken_out)
//  - RUN: dout<=acc>>>LOG2R (arithmetic shift = floor), acc<=acc+diff, phase<=phase+1.
//    When phase reaches R, state<=HOLD.
//  - HOLD: dout<=x1, slip pulses.
//  - IDLE: dout<=0, no slip.
//  - dout_stb pulses in every state on the cycle after the tick; latency tick->dout is 1 clock.
//  FSM
//  - IDLE -load-> RUN
//  - RUN -R-th tick-> HOLD
//  - HOLD -load-> RUN
//  - RUN -load-> RUN, with slip pulse (segment cut short).
//  Simultaneous load+tick (same cycle)
//  - Load applies first; the tick emits phase 0 of the new segment: dout<=x1_old.
//  - acc<=x1_old*R+diff_new, phase<=1.
//  - slip follows the pre-load state: pulses if RUN, not if HOLD or IDLE.
//  Width
//  - acc never leaves [min(x0,x1)*R, max(x0,x1)*R]; no wrap, no saturation needed.
//  - Output always lies within W bits.
//  Nominal rate: exactly R ticks between loads -> slip never asserts.
//  Reset mid-segment: everything returns to reset values at once; next load starts from x0=0.
// CONFIGURATION
//  LI_ROUND_EN defined
//  - dout = (acc + R/2) >>> LOG2R, i.e. round half up.
//  - acc width stays W+LOG2R+1; the endpoints x0 and x1 are reproduced exactly.
//  LI_ROUND_EN undefined: dout = acc >>> LOG2R (floor). No other behavioural change.
// TESTING (LOG2R=2, W=18)
//  1 Reset, then 3 ticks with no load -> dout=0 each, dout_stb pulses, slip=0.
//  2 Load 0, 4 ticks, load 400, 4 ticks, load 800, 4 ticks
//    -> 0,0,0,0 | 0,100,200,300 | 400,500,600,700; slip=0 throughout.
//  3 Segment x0=100, x1=-3
//    -> floor build: 100,74,48,22
//    -> LI_ROUND_EN build: 100,74,49,23.
//  4 Segment x0=-131072, x1=131071 -> -131072,-65537,-1,65535; no wrap; next segment starts at 131071.
//  5 After 4 ticks at x1=400, a 5th tick -> dout=400, slip pulse.
//    Then a load after only 2 ticks of the next segment -> slip pulse, new segment starts from the old x1.
//  6 Load and tick in the same cycle from HOLD (x1=400, din=800)
//    -> dout=400, slip=0, next tick 500.
//    Then assert reset mid-segment -> dout=0 in the same cycle, state IDLE.

Source files
------------

// File: rtl/lin_interp_48k.sv
`timescale 1ns/1ps
// lin_interp_48k
// Linear-interpolation upsampler that sits after the 48 kHz mix/scale stage.
// For each input period it produces R = 2**LOG2R points on the straight line
// from the previous sample (x0) to the newest sample (x1). It emits one point
// for each output-rate clock enable. Use one instance per channel.
//
// Configuration macro:
//   LI_ROUND_EN  defined   : dout = (acc + R/2) >>> LOG2R  (round half up)
//                undefined : dout = acc >>> LOG2R          (floor)
//
// Parameters:
//   W      sample width, signed two's complement (input and output)
//   LOG2R  log2 of the upsampling ratio; must be >= 1
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   clken_48   one-cycle strobe: din holds a new sample
//   clken_out  one-cycle strobe at output rate: emit the next point
//   din        signed input sample
//   dout       signed interpolated sample (registered)
//   dout_stb   one-cycle pulse: dout updated this cycle
//   slip       one-cycle pulse: clken_48 and clken_out rates disagree
module lin_interp_48k #(
  parameter int W     = 18,
  parameter int LOG2R = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clken_48,
  input  logic                clken_out,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout,
  output logic                dout_stb,
  output logic                slip
);

  localparam int R  = 1 << LOG2R;
  localparam int AW = W + LOG2R + 1;
  localparam int PW = $clog2(R + 1);

  localparam logic [AW-1:0] HALF = AW'(R / 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [W-1:0]  x0, x1;
  logic [AW-1:0] acc;
  logic [PW-1:0] phase;
  logic [1:0]    state;

  // Segment slopes are one bit wider than a sample. This lets a full-scale
  // swing be represented without wrap.
  logic [W:0]    diff_cur, diff_new;
  logic [AW-1:0] diff_cur_ext, diff_new_ext;
  logic [AW-1:0] acc_x1;   // x1 * R: the start of a segment that begins at x1
  logic [AW-1:0] acc_rnd;  // accumulator after the optional rounding bias
  logic          unused_rnd_bits;

  assign diff_cur     = {x1[W-1], x1} - {x0[W-1], x0};
  assign diff_new     = {din[W-1], din} - {x1[W-1], x1};
  assign diff_cur_ext = {{LOG2R{diff_cur[W]}}, diff_cur};
  assign diff_new_ext = {{LOG2R{diff_new[W]}}, diff_new};
  assign acc_x1       = {x1[W-1], x1, {LOG2R{1'b0}}};

`ifdef LI_ROUND_EN
  assign acc_rnd = acc + HALF;
`else
  assign acc_rnd = acc;
`endif

  // The accumulator stays between x0*R and x1*R. Taking bits
  // [W+LOG2R-1:LOG2R] is therefore the same as an arithmetic shift right
  // by LOG2R, and the result always fits in W bits.
  assign unused_rnd_bits = ^{acc_rnd[AW-1], acc_rnd[LOG2R-1:0]};

  // NOTE: every register in this block uses non-blocking assignments.
  // Each right-hand side then sees the value from before the edge. This
  // matters when a load and a tick arrive together: x1 must be read as the
  // old endpoint while it is being replaced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout     <= '0;
      dout_stb <= 1'b0;
      slip     <= 1'b0;
      x0       <= '0;
      x1       <= '0;
      acc      <= '0;
      phase    <= '0;
      state    <= IDLE;
    end else begin
      dout_stb <= clken_out;
      // The slip decision uses the state from before the load.
      // - A load during RUN cuts the current segment short.
      // - A tick during HOLD asks for more points than the segment has.
      slip <= (clken_48 && state == RUN) ||
              (clken_out && !clken_48 && state == HOLD);

      if (clken_48) begin
        x0 <= x1;
        x1 <= din;
        if (clken_out) begin
          // The load is applied first. The tick then emits phase 0 of the
          // new segment, which is the old x1.
          dout  <= x1;
          acc   <= acc_x1 + diff_new_ext;
          phase <= PW'(1);
          state <= (R == 1) ? HOLD : RUN;
        end else begin
          acc   <= acc_x1;
          phase <= '0;
          state <= RUN;
        end
      end else if (clken_out) begin
        case (state)
          RUN: begin
            dout  <= acc_rnd[W+LOG2R-1:LOG2R];
            acc   <= acc + diff_cur_ext;
            phase <= phase + PW'(1);
            if (phase == PW'(R - 1)) state <= HOLD;
          end
          HOLD:    dout <= x1;
          default: dout <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lin_interp_48k.sv
`timescale 1ns/1ps
// tb_lin_interp_48k
// Scoreboard bench for lin_interp_48k (W=18, LOG2R=2).
// Stimulus pushes the expected output events into a queue. A monitor pops
// and compares an event on every cycle where dout_stb or slip is high.
// Expected values are hand-derived. Where the floor and the round-half-up
// results differ, the value is selected with LI_ROUND_EN.
module tb_lin_interp_48k;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clken_48 = 1'b0;
  logic               clken_out = 1'b0;
  logic signed [17:0] din = '0;
  logic signed [17:0] dout;
  logic               dout_stb;
  logic               slip;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ev    = 0;

  typedef struct packed {
    logic               stb;
    logic signed [17:0] d;
    logic               slp;
  } ev_t;

  ev_t exp_q[$];

  lin_interp_48k #(.W(18), .LOG2R(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .clken_48 (clken_48),
    .clken_out(clken_out),
    .din      (din),
    .dout     (dout),
    .dout_stb (dout_stb),
    .slip     (slip)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active
  // clock edge.
  always @(negedge clock) begin
    if (!reset && (dout_stb || slip)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got stb=%0b dout=%0d slip=%0b, expected none",
                 dout_stb, dout, slip);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check($sformatf("ev%0d_stb", n_ev), int'(dout_stb), int'(e.stb));
        if (e.stb) check($sformatf("ev%0d_dout", n_ev), int'(dout), int'(e.d));
        check($sformatf("ev%0d_slip", n_ev), int'(slip), int'(e.slp));
        n_ev++;
      end
    end
  end

  task automatic push(input logic stb, input int d, input logic slp);
    ev_t e;
    e.stb = stb;
    e.d   = 18'(d);
    e.slp = slp;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic ld, input logic tk, input int v);
    @(posedge clock);
    #1;
    clken_48  = ld;
    clken_out = tk;
    din       = 18'(v);
    @(posedge clock);
    #1;
    clken_48  = 1'b0;
    clken_out = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic load(input int v);
    issue(1'b1, 1'b0, v);
  endtask

  task automatic tick(input int d, input logic slp);
    push(1'b1, d, slp);
    issue(1'b0, 1'b1, 0);
  endtask

  task automatic tick4(input int a, input int b, input int c, input int d);
    tick(a, 1'b0);
    tick(b, 1'b0);
    tick(c, 1'b0);
    tick(d, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_stb"},  int'(dout_stb), 0);
    check({tag, "_slip"}, int'(slip), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: ticks with no load give zeros and no slip.
    tick(0, 1'b0);
    tick(0, 1'b0);
    tick(0, 1'b0);

    // 2: nominal-rate ramp.
    load(0);
    tick4(0, 0, 0, 0);
    load(400);
    tick4(0, 100, 200, 300);
    load(800);
    tick4(400, 500, 600, 700);

    // 3: falling segments. 100 -> -3 shows the floor/round difference.
    load(100);
    tick4(800, 625, 450, 275);
    load(-3);
`ifdef LI_ROUND_EN
    tick4(100, 74, 49, 23);
`else
    tick4(100, 74, 48, 22);
`endif

    // 5: overrun and underrun.
    load(400);
`ifdef LI_ROUND_EN
    tick4(-3, 98, 199, 299);
`else
    tick4(-3, 97, 198, 299);
`endif
    tick(400, 1'b1);              // fifth tick in HOLD
    load(800);
    tick(400, 1'b0);
    tick(500, 1'b0);
    push(1'b0, 0, 1'b1);          // load during RUN cuts the segment short
    load(1200);
    tick4(800, 900, 1000, 1100);  // restarts from the old x1

    // 6: simultaneous load + tick from HOLD, then reset mid-segment.
    load(400);
    tick4(1200, 1000, 800, 600);
    push(1'b1, 400, 1'b0);
    issue(1'b1, 1'b1, 800);
    tick(500, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(0, 1'b0);                // back in IDLE

    // 4: full-scale swing, starting from x0 = 0 after reset.
    load(-131072);
    tick4(0, -32768, -65536, -98304);
    load(131071);
`ifdef LI_ROUND_EN
    tick4(-131072, -65536, 0, 65535);
`else
    tick4(-131072, -65537, -1, 65535);
`endif
    load(131071);
    tick(131071, 1'b0);           // next segment starts at 131071
    tick(131071, 1'b0);
    push(1'b1, 131071, 1'b1);     // load + tick from RUN: slip pulses
    issue(1'b1, 1'b1, 0);
    tick(98303, 1'b0);

    repeat (5) @(posedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
